rgb_pattern_sequencer: RTL and testbench
========================================

Name: rgb_pattern_sequencer

Overview:
Programmable colour-pattern controller that generates the three PWM inputs and the enable for the iCE40 SB_RGBA_DRV hard LED driver. It holds a 4-entry step table; each entry gives an 8-bit duty per colour and a hold time in PWM frames. Once started, it steps through the table, either once or looping, and applies new duties only on PWM frame boundaries. It sits between the top-level control logic and the RGB driver primitive, replacing free-running counter bit taps.

Parameters:
CLK_DIV, 47, prescaler terminal count; one PWM tick every CLK_DIV+1 clocks
DUTY_W, 8, duty and PWM counter width; frame = 2^DUTY_W ticks
HOLD_W, 16, width of per-step hold count, in frames
STEP_W, 2, step index width; table depth = 2^STEP_W = 4

Ports:
clk  in  1  system clock (SB_HFOSC output)
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request: begin the sequence at step 0
stop  in  1  single-cycle request: abort immediately
loop_en  in  1  1 = wrap from last_step to step 0; 0 = run once
last_step  in  STEP_W  index of the final step in the sequence
cfg_we  in  1  table write strobe
cfg_addr  in  STEP_W  table entry to write
cfg_red  in  DUTY_W  red duty for the entry
cfg_green  in  DUTY_W  green duty for the entry
cfg_blue  in  DUTY_W  blue duty for the entry
cfg_hold  in  HOLD_W  hold frames for the entry; 0 is treated as 1
pwm_red  out  1  to the RGB driver red PWM input
pwm_green  out  1  to the RGB driver green PWM input
pwm_blue  out  1  to the RGB driver blue PWM input
led_en  out  1  to RGBLEDEN and CURREN; high while running
busy  out  1  state is RUN
cur_step  out  STEP_W  step currently displayed
step_pulse  out  1  one-cycle pulse on each step advance
done  out  1  one-cycle pulse when a non-looping run ends

Behaviour:
- Clocking: single clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: every table entry is 0. All outputs are 0. State is IDLE, and all counters are 0.
- States: IDLE and RUN.
  - IDLE -> RUN when start=1 and stop=0.
  - RUN -> IDLE on stop, or at the end of the final frame of last_step when loop_en=0.
- stop has priority over start, over the step advance and over frame events. start is ignored while in RUN.
- Start action, on the start edge:
  - prescaler, pwm_cnt and hold_cnt are cleared; cur_step is 0.
  - The active duty registers load from table[0].
  - pwm_* and led_en go high from the second cycle after start is sampled; both outputs are registered.
- Tick and counter rules:
  - tick = (prescaler == CLK_DIV). On tick, prescaler is cleared and pwm_cnt increments, wrapping from 2^DUTY_W-1 to 0.
  - Frame end = tick with pwm_cnt == max.
- PWM output: pwm_x is registered as (duty_x > pwm_cnt).
  - duty 0 gives a constant low output.
  - duty 255 gives 255 of every 256 ticks high.
- Frame end in RUN:
  - If hold_cnt+1 >= max(hold[cur_step],1): advance the step, clear hold_cnt, pulse step_pulse.
    - If cur_step == last_step: wrap to 0 when loop_en=1; otherwise go to IDLE and pulse done.
  - Otherwise: hold_cnt increments.
  - In both cases, the active duties reload from the table entry for the next displayed step. This reload happens only at frame end, so duties are glitch-free.
- Table writes:
  - Accepted in any state.
  - A write coinciding with a reload of the same address: the old value is loaded and the new value takes effect on the next reload.
  - Writes to the currently displayed step become visible at the next frame end.
- last_step and loop_en are sampled at each frame end; changing them mid-run is legal.
- On leaving RUN, whether by stop or by run end:
  - pwm_*, led_en and busy go low on the next edge.
  - cur_step holds its last value until the next start.
- Reset mid-run: immediate return to the reset values; the table is also cleared.

Decomposition:
- Package rgb_seq_pkg holds:
  - the state enum (IDLE, RUN);
  - DUTY_W, HOLD_W, STEP_W defaults;
  - the step-entry struct {red, green, blue, hold}.
- Sub-module rgb_pwm_gen contains the prescaler, pwm_cnt, the three registered comparators and the frame_end output.
- The sequencer FSM, step table and hold counter live in the top level.

Test Plan:
(All scenarios use CLK_DIV=0, so 1 tick = 1 clk and 1 frame = 256 clk.)
- Duty check: step0 = R128 G0 B255, hold 1, last_step 0, loop 1, start. Measure over one frame after latency -> red high 128 clk, green 0, blue 255; led_en=1.
- One-shot sequence: steps 0..1, hold 2 each, loop 0, start at t0. Expect:
  - step_pulse at the frame ends 2 and 4;
  - done pulse at the end of frame 4 (about t0+1025);
  - busy, led_en and pwm_* low on the next cycle.
- Loop wrap: last_step 3, loop 1, hold 1 -> cur_step runs 0,1,2,3,0,1 at successive frame ends; done never asserts.
- Hold 0: cfg_hold=0 on step 1 -> step 1 is displayed for exactly 1 frame.
- Stop mid-frame: stop at pwm_cnt=100 -> outputs and busy low on the next edge. Simultaneous start+stop in IDLE -> stays IDLE.
- Live rewrite and reset: write step 0 red=10 mid-frame while running -> the old duty is kept until frame end, then 10 clk high per frame. Assert rst_n low mid-frame -> all outputs 0 asynchronously; after release, start yields all-zero duties.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// Shared types and default widths for the RGB pattern sequencer.
package rgb_seq_pkg;

  localparam int DEF_DUTY_W = 8;
  localparam int DEF_HOLD_W = 16;
  localparam int DEF_STEP_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [DEF_DUTY_W-1:0] red;
    logic [DEF_DUTY_W-1:0] green;
    logic [DEF_DUTY_W-1:0] blue;
    logic [DEF_HOLD_W-1:0] hold;
  } step_entry_t;

endpackage

// File: rtl/rgb_pwm_gen.sv
// Prescaled PWM timebase with three registered duty comparators and a
// frame_end strobe on the last tick of each 2^DUTY_W-tick frame.
module rgb_pwm_gen #(
  parameter int CLK_DIV = 47,
  parameter int DUTY_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              out_en,
  input  logic [DUTY_W-1:0] duty_red,
  input  logic [DUTY_W-1:0] duty_green,
  input  logic [DUTY_W-1:0] duty_blue,
  output logic              pwm_red,
  output logic              pwm_green,
  output logic              pwm_blue,
  output logic              frame_end
);

  localparam int                PRE_W   = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [PRE_W-1:0]  PRE_TC  = PRE_W'(CLK_DIV);
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0]  prescaler;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              tick;

  assign tick      = (prescaler == PRE_TC);
  assign frame_end = run && tick && (pwm_cnt == CNT_MAX);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  // Counters are held at zero outside RUN, so a start always begins a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (!run) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      prescaler <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      pwm_red   <= out_en && (duty_red   > pwm_cnt);
      pwm_green <= out_en && (duty_green > pwm_cnt);
      pwm_blue  <= out_en && (duty_blue  > pwm_cnt);
    end
  end

endmodule

// File: rtl/rgb_pattern_sequencer.sv
// Step-table colour sequencer driving SB_RGBA_DRV PWM inputs and enable.
// Width parameters must match the rgb_seq_pkg defaults used by step_entry_t.
module rgb_pattern_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int CLK_DIV = 47,
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [STEP_W-1:0] last_step,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [DUTY_W-1:0] cfg_red,
  input  logic [DUTY_W-1:0] cfg_green,
  input  logic [DUTY_W-1:0] cfg_blue,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              pwm_red,
  output logic              pwm_green,
  output logic              pwm_blue,
  output logic              led_en,
  output logic              busy,
  output logic [STEP_W-1:0] cur_step,
  output logic              step_pulse,
  output logic              done
);

  localparam int DEPTH = 2 ** STEP_W;

  seq_state_t        state, state_next;
  step_entry_t       step_table [DEPTH];
  logic [HOLD_W-1:0] hold_cnt;
  logic [DUTY_W-1:0] act_red, act_green, act_blue;
  logic [HOLD_W-1:0] hold_eff;
  logic              hold_reached;
  logic              frame_end;
  logic              frame_event;
  logic              start_go;
  logic              run_end;
  logic              out_en;
  logic [STEP_W-1:0] next_step;

  assign hold_eff     = (step_table[cur_step].hold == '0) ? HOLD_W'(1) : step_table[cur_step].hold;
  assign hold_reached = ({1'b0, hold_cnt} + 1'b1) >= {1'b0, hold_eff};
  assign frame_event  = (state == RUN) && !stop && frame_end;
  assign start_go     = (state == IDLE) && (state_next == RUN);
  assign out_en       = (state == RUN) && (state_next == RUN);
  assign busy         = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first so no path through the block leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    next_step  = cur_step;
    run_end    = 1'b0;
    case (state)
      IDLE: if (start && !stop) state_next = RUN;
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (frame_end && hold_reached) begin
          if (cur_step != last_step) begin
            next_step = cur_step + 1'b1;
          end else if (loop_en) begin
            next_step = '0;
          end else begin
            run_end    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the table is a small register file, not RAM, so it takes the async reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) step_table[i] <= '0;
    end else if (cfg_we) begin
      step_table[cfg_addr] <= '{red: cfg_red, green: cfg_green, blue: cfg_blue, hold: cfg_hold};
    end
  end

  // Active duties reload only at frame end; a same-edge table write is seen one reload later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_step   <= '0;
      hold_cnt   <= '0;
      act_red    <= '0;
      act_green  <= '0;
      act_blue   <= '0;
      led_en     <= 1'b0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      led_en     <= out_en;
      step_pulse <= frame_event && hold_reached;
      done       <= run_end;
      if (start_go) begin
        cur_step  <= '0;
        hold_cnt  <= '0;
        act_red   <= step_table[0].red;
        act_green <= step_table[0].green;
        act_blue  <= step_table[0].blue;
      end else if (frame_event) begin
        cur_step <= next_step;
        hold_cnt <= hold_reached ? '0 : hold_cnt + 1'b1;
        if (!run_end) begin
          act_red   <= step_table[next_step].red;
          act_green <= step_table[next_step].green;
          act_blue  <= step_table[next_step].blue;
        end
      end
    end
  end

  rgb_pwm_gen #(
    .CLK_DIV (CLK_DIV),
    .DUTY_W  (DUTY_W)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state == RUN),
    .out_en     (out_en),
    .duty_red   (act_red),
    .duty_green (act_green),
    .duty_blue  (act_blue),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue),
    .frame_end  (frame_end)
  );

endmodule

// File: tb/tb_rgb_pattern_sequencer.sv
// Directed bench for rgb_pattern_sequencer with CLK_DIV=0 (1 frame = 256 clk).
module tb_rgb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, loop_en, cfg_we;
  logic [1:0] last_step, cfg_addr;
  logic [7:0] cfg_red, cfg_green, cfg_blue;
  logic [15:0] cfg_hold;
  logic       pwm_red, pwm_green, pwm_blue, led_en, busy, step_pulse, done;
  logic [1:0] cur_step;

  int vectors    = 0;
  int miscompares = 0;

  rgb_pattern_sequencer #(.CLK_DIV(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .last_step  (last_step),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_red    (cfg_red),
    .cfg_green  (cfg_green),
    .cfg_blue   (cfg_blue),
    .cfg_hold   (cfg_hold),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue),
    .led_en     (led_en),
    .busy       (busy),
    .cur_step   (cur_step),
    .step_pulse (step_pulse),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled on the following rising edge.
  task automatic write_entry(input logic [1:0] a, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic [15:0] h);
    cfg_we = 1'b1; cfg_addr = a; cfg_red = r; cfg_green = g; cfg_blue = b; cfg_hold = h;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int red_cnt [4];
  int grn_cnt, blu_cnt, led_cnt;
  int sp_n, sp1, sp2, done_n, done_k, busy_low_k, step_mid;
  int exp_step [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_step = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_red = '0; cfg_green = '0; cfg_blue = '0; cfg_hold = '0;
    #12;
    check("reset_pwm",    {pwm_red, pwm_green, pwm_blue}, 0);
    check("reset_ctrl",   {led_en, busy, step_pulse, done}, 0);
    check("reset_step",   cur_step, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Duty check: R128 G0 B255 over one full frame.
    write_entry(2'd0, 8'd128, 8'd0, 8'd255, 16'd1);
    last_step = 2'd0; loop_en = 1'b1;
    pulse_start();
    check("start_busy",    busy, 1);
    check("start_latency", {led_en, pwm_blue}, 0);
    red_cnt[0] = 0; grn_cnt = 0; blu_cnt = 0; led_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      red_cnt[0] += int'(pwm_red); grn_cnt += int'(pwm_green);
      blu_cnt += int'(pwm_blue); led_cnt += int'(led_en);
    end
    check("duty_red128",   red_cnt[0], 128);
    check("duty_green0",   grn_cnt, 0);
    check("duty_blue255",  blu_cnt, 255);
    check("duty_led_en",   led_cnt, 256);

    // Stop mid-frame at pwm_cnt=100.
    repeat (100) @(negedge clk);
    check("pre_stop_red",  pwm_red, 1);
    pulse_stop();
    check("stop_busy",     busy, 0);
    check("stop_outs",     {led_en, pwm_red, pwm_blue}, 0);

    // Simultaneous start and stop in IDLE.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", busy, 0);
    @(negedge clk);
    check("start_stop_led",  {busy, led_en}, 0);

    // One-shot two-step run, hold 2 frames each.
    write_entry(2'd0, 8'd50,  8'd0, 8'd0, 16'd2);
    write_entry(2'd1, 8'd200, 8'd0, 8'd0, 16'd2);
    last_step = 2'd1; loop_en = 1'b0;
    pulse_start();
    red_cnt = '{0, 0, 0, 0};
    sp_n = 0; sp1 = 0; sp2 = 0; done_n = 0; done_k = 0; busy_low_k = 0; step_mid = -1;
    for (int k = 2; k <= 1030; k++) begin
      @(negedge clk);
      if ((k - 2) / 256 < 4) red_cnt[(k - 2) / 256] += int'(pwm_red);
      if (step_pulse) begin
        sp_n++;
        if (sp_n == 1) sp1 = k; else sp2 = k;
      end
      if (done) begin done_n++; done_k = k; end
      if (!busy && busy_low_k == 0) busy_low_k = k;
      if (k == 600) step_mid = int'(cur_step);
    end
    check("oneshot_red_f0", red_cnt[0], 50);
    check("oneshot_red_f1", red_cnt[1], 50);
    check("oneshot_red_f2", red_cnt[2], 200);
    check("oneshot_red_f3", red_cnt[3], 200);
    check("oneshot_sp_n",   sp_n, 2);
    check("oneshot_sp1",    sp1, 513);
    check("oneshot_sp2",    sp2, 1025);
    check("oneshot_done_n", done_n, 1);
    check("oneshot_done_k", done_k, 1025);
    check("oneshot_busy_k", busy_low_k, 1025);
    check("oneshot_step1",  step_mid, 1);
    check("oneshot_after",  {led_en, pwm_red, pwm_green, pwm_blue}, 0);
    check("oneshot_hold",   cur_step, 1);

    // Loop wrap over four steps; step 1 has hold 0 and lasts one frame.
    write_entry(2'd0, 8'd10, 8'd20, 8'd30, 16'd1);
    write_entry(2'd1, 8'd40, 8'd0,  8'd0,  16'd0);
    write_entry(2'd2, 8'd0,  8'd60, 8'd0,  16'd1);
    write_entry(2'd3, 8'd0,  8'd0,  8'd90, 16'd1);
    last_step = 2'd3; loop_en = 1'b1;
    pulse_start();
    sp_n = 0; done_n = 0;
    for (int k = 2; k <= 1282; k++) begin
      @(negedge clk);
      if ((k - 2) % 256 == 0)
        check($sformatf("loop_step_f%0d", (k - 2) / 256), cur_step, exp_step[(k - 2) / 256]);
      sp_n   += int'(step_pulse);
      done_n += int'(done);
    end
    check("loop_sp_n",   sp_n, 5);
    check("loop_done_n", done_n, 0);
    pulse_stop();

    // Live rewrite of the displayed step, including a write on a reload edge.
    write_entry(2'd0, 8'd200, 8'd0, 8'd0, 16'd1);
    last_step = 2'd0; loop_en = 1'b1;
    pulse_start();
    red_cnt = '{0, 0, 0, 0};
    for (int k = 2; k <= 1025; k++) begin
      @(negedge clk);
      red_cnt[(k - 2) / 256] += int'(pwm_red);
      cfg_we = 1'b0;
      if (k == 101 || k == 512) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_green = '0; cfg_blue = '0; cfg_hold = 16'd1;
        cfg_red = (k == 101) ? 8'd10 : 8'd77;
      end
    end
    cfg_we = 1'b0;
    check("rewrite_f0", red_cnt[0], 200);
    check("rewrite_f1", red_cnt[1], 10);
    check("rewrite_f2", red_cnt[2], 10);
    check("rewrite_f3", red_cnt[3], 77);

    // Asynchronous reset mid-frame clears outputs and the table.
    repeat (5) @(negedge clk);
    check("pre_reset_red", pwm_red, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {pwm_red, pwm_green, pwm_blue, led_en, busy}, 0);
    check("async_rst_step", cur_step, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    red_cnt[0] = 0; grn_cnt = 0; blu_cnt = 0; led_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      red_cnt[0] += int'(pwm_red); grn_cnt += int'(pwm_green);
      blu_cnt += int'(pwm_blue); led_cnt += int'(led_en);
    end
    check("post_rst_duty", red_cnt[0] + grn_cnt + blu_cnt, 0);
    check("post_rst_led",  led_cnt, 256);
    pulse_stop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
